top: RTL and testbench

TOP -- requirements
Module: top

---
 rtl/vga_pkg.sv | 52 +++++
 rtl/image_rom.sv | 36 +++
 rtl/vga_sync.sv | 88 ++++++++
 rtl/top.sv | 121 ++++++++++++
 tb/tb_top.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// vga_pkg
// Shared VGA timing and image constants for the 640x480 @ 60 Hz display
// path, the colour word layout and the image content generator.
// No ports; imported by vga_sync, image_rom and top.
package vga_pkg;

    // Horizontal timing in pixel clocks.
    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    // Vertical timing in lines.
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Sync pulse positions (inclusive bounds).
    localparam int H_SYNC_START = H_ACTIVE + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
    localparam int V_SYNC_START = V_ACTIVE + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

    // Source image, shown pixel-doubled in both directions.
    localparam int IMG_W     = 320;
    localparam int IMG_H     = 240;
    localparam int IMG_DEPTH = IMG_W * IMG_H;

    // Port widths.
    localparam int X_W    = 11;
    localparam int Y_W    = 10;
    localparam int ADDR_W = 17;
    localparam int PIX_W  = 12;

    // One image word: 4 bits per channel, red in the top nibble.
    typedef struct packed {
        logic [3:0] red;
        logic [3:0] green;
        logic [3:0] blue;
    } rgb_t;

    // Image content as a function of the word address. The low 12 address
    // bits give a repeating gradient and the high bits shift it, so every
    // 4096-word block of the picture looks different.
    function automatic logic [PIX_W-1:0] rom_pattern(input logic [ADDR_W-1:0] addr);
        return addr[11:0] + {7'b0, addr[16:12]};
    endfunction

endpackage

// File: rtl/image_rom.sv
// image_rom
// Read-only image store, one 12-bit {R,G,B} word per source pixel, with a
// registered read port (data follows addr by one clock). The content is
// produced by vga_pkg::rom_pattern so the picture is fixed at build time
// without any external memory image.
// Ports:
//   clk  - system clock
//   addr - word address, 0..DEPTH-1
//   data - word at the address presented on the previous clock
module image_rom
    import vga_pkg::*;
#(
    parameter int DEPTH = IMG_DEPTH
)(
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    output logic [PIX_W-1:0]  data
);

    logic [PIX_W-1:0] data_q, data_d;

    // Addresses past the end of the image read as black.
    always_comb begin
        data_d = '0;
        if (addr < ADDR_W'(DEPTH)) begin
            data_d = rom_pattern(addr);
        end
    end

    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign data = data_q;

endmodule

// File: rtl/vga_sync.sv
// vga_sync
// Pixel-rate divider, horizontal/vertical counters and the combinational
// sync/active decode for one VGA raster.
// Ports:
//   clk    - system clock (4x the pixel rate)
//   reset  - synchronous active-high reset
//   tick   - high for one clk every 4, the pixel strobe
//   x, y   - current pixel / line position
//   active - position lies inside the visible area
//   hs_n   - horizontal sync for the current x, active low
//   vs_n   - vertical sync for the current y, active low
module vga_sync
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int H_FP     = vga_pkg::H_FP,
    parameter int H_SYNC   = vga_pkg::H_SYNC,
    parameter int H_BP     = vga_pkg::H_BP,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int V_FP     = vga_pkg::V_FP,
    parameter int V_SYNC   = vga_pkg::V_SYNC,
    parameter int V_BP     = vga_pkg::V_BP
)(
    input  logic           clk,
    input  logic           reset,
    output logic           tick,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           active,
    output logic           hs_n,
    output logic           vs_n
);

    localparam int LINE_LEN  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int FRAME_LEN = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START  = H_ACTIVE + H_FP;
    localparam int HS_END    = HS_START + H_SYNC - 1;
    localparam int VS_START  = V_ACTIVE + V_FP;
    localparam int VS_END    = VS_START + V_SYNC - 1;

    logic [1:0]     div_q, div_d;
    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;

    // The divider free-runs; its last state marks the pixel strobe.
    assign tick = (div_q == 2'd3);

    always_comb begin
        div_d = div_q + 2'd1;
        x_d   = x_q;
        y_d   = y_q;
        if (tick) begin
            if (x_q == X_W'(LINE_LEN - 1)) begin
                x_d = '0;
                if (y_q == Y_W'(FRAME_LEN - 1)) begin
                    y_d = '0;
                end else begin
                    y_d = y_q + Y_W'(1);
                end
            end else begin
                x_d = x_q + X_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q <= '0;
            x_q   <= '0;
            y_q   <= '0;
        end else begin
            div_q <= div_d;
            x_q   <= x_d;
            y_q   <= y_d;
        end
    end

    // Decode of the current position; top registers these on the strobe.
    always_comb begin
        active = (x_q < X_W'(H_ACTIVE)) && (y_q < Y_W'(V_ACTIVE));
        hs_n   = !((x_q >= X_W'(HS_START)) && (x_q <= X_W'(HS_END)));
        vs_n   = !((y_q >= Y_W'(VS_START)) && (y_q <= Y_W'(VS_END)));
    end

    assign x = x_q;
    assign y = y_q;

endmodule

// File: rtl/top.sv
// top
// VGA scan-out of a pixel-doubled image. vga_sync produces the raster
// position, top turns it into an image address, and the sync and colour
// outputs are registered on the pixel strobe so they trail x/y by one pixel.
// Ports:
//   CLK100MHZ          - 100 MHz system clock
//   reset              - synchronous active-high reset
//   vgaRed/Green/Blue  - 4-bit colour DAC values, black during blanking
//   Hsync, Vsync       - sync pulses, active low
//   x, y               - current raster position
//   addra              - image address for (x,y), 0 outside the visible area
module top
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int H_FP     = vga_pkg::H_FP,
    parameter int H_SYNC   = vga_pkg::H_SYNC,
    parameter int H_BP     = vga_pkg::H_BP,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int V_FP     = vga_pkg::V_FP,
    parameter int V_SYNC   = vga_pkg::V_SYNC,
    parameter int V_BP     = vga_pkg::V_BP,
    parameter int IMG_W    = vga_pkg::IMG_W,
    parameter int IMG_H    = vga_pkg::IMG_H
)(
    input  logic              CLK100MHZ,
    input  logic              reset,
    output logic [3:0]        vgaRed,
    output logic [3:0]        vgaGreen,
    output logic [3:0]        vgaBlue,
    output logic              Hsync,
    output logic              Vsync,
    output logic [X_W-1:0]    x,
    output logic [Y_W-1:0]    y,
    output logic [ADDR_W-1:0] addra
);

    logic             tick;
    logic             active;
    logic             hs_n;
    logic             vs_n;
    logic [PIX_W-1:0] rom_data;

    logic hsync_q, hsync_d;
    logic vsync_q, vsync_d;
    rgb_t rgb_q, rgb_d;

    vga_sync #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_sync (
        .clk    (CLK100MHZ),
        .reset  (reset),
        .tick   (tick),
        .x      (x),
        .y      (y),
        .active (active),
        .hs_n   (hs_n),
        .vs_n   (vs_n)
    );

    // Each source pixel covers a 2x2 block on screen, so both coordinates
    // are halved before forming the row-major image address.
    always_comb begin
        addra = '0;
        if (active) begin
            addra = ADDR_W'(y[Y_W-1:1]) * ADDR_W'(IMG_W) + ADDR_W'(x[X_W-1:1]);
        end
    end

    image_rom #(
        .DEPTH (IMG_W * IMG_H)
    ) u_rom (
        .clk  (CLK100MHZ),
        .addr (addra),
        .data (rom_data)
    );

    // The address only moves on a strobe, so by the next strobe the ROM
    // has long since caught up; capture sync and colour for the pixel that
    // is just finishing.
    always_comb begin
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        rgb_d   = rgb_q;
        if (tick) begin
            hsync_d = hs_n;
            vsync_d = vs_n;
            if (active) begin
                rgb_d = rgb_t'(rom_data);
            end else begin
                rgb_d = '0;
            end
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            rgb_q   <= '0;
        end else begin
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            rgb_q   <= rgb_d;
        end
    end

    assign Hsync    = hsync_q;
    assign Vsync    = vsync_q;
    assign vgaRed   = rgb_q.red;
    assign vgaGreen = rgb_q.green;
    assign vgaBlue  = rgb_q.blue;

endmodule

// File: tb/tb_top.sv
// tb_top
// Drives two copies of top from one clock and reset: "big" with the real
// 640x480 timing and "small" with a shrunken raster so whole frames, Vsync
// and frame wrap fit in a short run. A position model derived from the
// number of clocks since reset predicts every output of both copies on
// every falling edge; a few fixed points are also checked directly.
module tb_top;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    logic [3:0]  redA, greenA, blueA, redB, greenB, blueB;
    logic        hsA, vsA, hsB, vsB;
    logic [10:0] xA, xB;
    logic [9:0]  yA, yB;
    logic [16:0] addrA, addrB;

    top dutBig (
        .CLK100MHZ (clk),
        .reset     (reset),
        .vgaRed    (redA),
        .vgaGreen  (greenA),
        .vgaBlue   (blueA),
        .Hsync     (hsA),
        .Vsync     (vsA),
        .x         (xA),
        .y         (yA),
        .addra     (addrA)
    );

    top #(
        .H_ACTIVE (16), .H_FP (2), .H_SYNC (4), .H_BP (2),
        .V_ACTIVE (12), .V_FP (2), .V_SYNC (2), .V_BP (2),
        .IMG_W    (8),  .IMG_H (6)
    ) dutSmall (
        .CLK100MHZ (clk),
        .reset     (reset),
        .vgaRed    (redB),
        .vgaGreen  (greenB),
        .vgaBlue   (blueB),
        .Hsync     (hsB),
        .Vsync     (vsB),
        .x         (xB),
        .y         (yB),
        .addra     (addrB)
    );

    int vecCount = 0;
    int failCount = 0;
    int nClk = 0;
    bit checkEn = 1'b0;

    // Clocks since the last edge that saw reset high.
    always @(posedge clk) begin
        if (reset) nClk <= 0;
        else       nClk <= nClk + 1;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vecCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s at t=%0t n=%0d: got %h, want %h", tag, $time, nClk, observed, expected);
        end
    endtask

    function automatic int romWord(input int a);
        return (a % 4096 + a / 4096) % 4096;
    endfunction

    function automatic int pixAddr(input int px, input int py, input int ha, input int va, input int iw);
        if (px < ha && py < va) return (py / 2) * iw + px / 2;
        return 0;
    endfunction

    // Expected output bundle n clocks after reset:
    // {12'h0, rgb, Hsync, Vsync, x, y, addra}.
    function automatic logic [63:0] expectVec(input int ha, input int hf, input int hsw, input int hb,
                                              input int va, input int vf, input int vsw, input int vb,
                                              input int iw, input int n);
        int htot, vtot, p, cx, cy, q, px, py;
        logic [11:0] rgb;
        logic hs, vs;
        htot = ha + hf + hsw + hb;
        vtot = va + vf + vsw + vb;
        p  = n / 4;
        cx = p % htot;
        cy = (p / htot) % vtot;
        if (p == 0) begin
            hs = 1'b1;
            vs = 1'b1;
            rgb = '0;
        end else begin
            q  = p - 1;
            px = q % htot;
            py = (q / htot) % vtot;
            hs = !(px >= ha + hf && px < ha + hf + hsw);
            vs = !(py >= va + vf && py < va + vf + vsw);
            rgb = (px < ha && py < va) ? 12'(romWord(pixAddr(px, py, ha, va, iw))) : 12'h0;
        end
        return {12'h0, rgb, hs, vs, 11'(cx), 10'(cy), 17'(pixAddr(cx, cy, ha, va, iw))};
    endfunction

    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("bigFrame", {12'h0, redA, greenA, blueA, hsA, vsA, xA, yA, addrA},
                        expectVec(640, 16, 96, 48, 480, 10, 2, 33, 320, nClk));
            checkOutput("smallFrame", {12'h0, redB, greenB, blueB, hsB, vsB, xB, yB, addrB},
                        expectVec(16, 2, 4, 2, 12, 2, 2, 2, 8, nClk));
        end
    end

    // Run for runClocks, then hold reset for resetClocks; all changes on
    // falling edges so the rising edge sees a settled reset.
    task automatic applyStimulus(input int runClocks, input int resetClocks);
        repeat (runClocks) @(negedge clk);
        reset = 1'b1;
        repeat (resetClocks) @(negedge clk);
        reset = 1'b0;
    endtask

    // Step to the falling edge where nClk equals target, bounded.
    task automatic waitCount(input int target);
        int guard = 0;
        while (nClk != target && guard < target + 16) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("reachCount", 64'(nClk), 64'(target));
    endtask

    initial begin
        reset = 1'b1;
        @(posedge clk);
        checkEn = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // First strobe lands on the fourth clock after release.
        waitCount(3);
        checkOutput("xBeforeFirstTick", 64'(xA), 64'd0);
        waitCount(4);
        checkOutput("xAfterFirstTick", 64'(xA), 64'd1);

        // Long clean run: two big lines, several small frames.
        applyStimulus(8000, 1);

        // Random run lengths and reset pulse widths, resets land mid-frame.
        for (int i = 0; i < 6 && failCount < 200; i++) begin
            applyStimulus($urandom_range(4000, 300), $urandom_range(3, 1));
        end

        applyStimulus(20, 2);

        // Fixed points after a fresh reset.
        waitCount(1116);
        checkOutput("smallLastActiveAddr", 64'(addrB), 64'd47);
        waitCount(2624);
        checkOutput("hsyncBeforeStart", 64'(hsA), 64'd1);
        waitCount(2628);
        checkOutput("hsyncStartsLate", 64'(hsA), 64'd0);
        waitCount(3008);
        checkOutput("hsyncLastLow", 64'(hsA), 64'd0);
        waitCount(3012);
        checkOutput("hsyncEnd", 64'(hsA), 64'd1);
        waitCount(3204);
        checkOutput("addrX1Y1", 64'(addrA), 64'd0);
        waitCount(6000);
        checkOutput("addrX700Y1", 64'(addrA), 64'd0);
        waitCount(6408);
        checkOutput("addrX2Y2", 64'(addrA), 64'd321);

        repeat (200) @(negedge clk);
        checkEn = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, failCount);
        $finish;
    end

endmodule
